// File: rtl/timer_counter_pkg.sv
// Shared encodings for the memory-mapped down-counting timer: FSM states,
// register offsets, CTRL bit positions and mode codes.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_W        = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Merge a bus write into a 32-bit register, one byte lane per enable bit.
  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wr,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wr[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit down-counting bus timer with one-shot / auto-reload modes and a
// maskable interrupt.
//
// state | meaning
// IDLE  | waiting for CTRL.EN
// LOAD  | copy PRESET into COUNT
// CNT   | decrement COUNT towards the terminal value 0
// INT   | expiry seen; one-shot clears EN, reload drops the pulse
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [31:0]         preset_q, preset_d;
  logic [31:0]         count_q, count_d;
  logic                irq_flag_q, irq_flag_d;

  logic                sel;
  logic [1:0]          offset;
  logic                wr_any;
  logic                wr_ctrl;
  logic                wr_preset;
  logic [1:0]          mode;
  logic                unused_addr;

  assign unused_addr = ^addr[1:0];

  always_comb begin
    sel       = (addr[31:4] == BASE_ADDR[31:4]);
    offset    = addr[3:2];
    wr_any    = sel && we && (byteen != 4'b0000);
    wr_ctrl   = wr_any && (offset == OFF_CTRL);
    wr_preset = wr_any && (offset == OFF_PRESET);
    mode      = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];
  end

  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (offset)
        OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
        OFF_PRESET: rdata = preset_q;
        OFF_COUNT:  rdata = count_q;
        default:    rdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'h0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        // Codes 10/11 fall back to one-shot behaviour.
        if (mode == MODE_RELOAD) begin
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A configuration write restarts the sequencer and wins over the FSM.
    if (wr_ctrl || wr_preset) begin
      irq_flag_d = 1'b0;
      state_d    = ST_IDLE;
      count_d    = count_q;
    end
    if (wr_ctrl && byteen[0]) begin
      ctrl_d = wdata[CTRL_W-1:0];
    end
    if (wr_preset) begin
      preset_d = merge_lanes(preset_q, wdata, byteen);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= 32'h0;
      count_q    <= 32'h0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  assign irq = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: randomized presets and bus writes
// compared against an event-time model of the timer.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_PRESET = BASE + 32'h4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = BASE + 32'hC;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_checks;
  int n_fail;
  logic [31:0] m_preset;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    @(negedge clk);
    addr   = a;
    wdata  = d;
    byteen = be;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we     = 1'b0;
    byteen = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] addrs [4];
    addrs = '{A_CTRL, A_PRESET, A_COUNT, A_RSVD};
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b1;
    m_preset = 32'h0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus_read(addrs[i], r);
      n_checks++;
      if (r !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read addr=%h got=%h exp=00000000", addrs[i], r);
      end
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq got=%b exp=0", irq);
    end
    bus_write(A_PRESET, 32'h1234_5678, 4'b0011);
    m_preset = 32'h0000_5678;
    bus_read(A_PRESET, r);
    n_checks++;
    if (r !== 32'h0000_5678) begin
      n_fail++;
      $display("FAIL preset_lanes got=%h exp=00005678", r);
    end
    for (int i = 0; i < 6; i++) begin
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      bus_write(A_PRESET, d, be);
      for (int l = 0; l < 4; l++) begin
        if (be[l]) m_preset[8*l +: 8] = d[8*l +: 8];
      end
      bus_read(A_PRESET, r);
      n_checks++;
      if (r !== m_preset) begin
        n_fail++;
        $display("FAIL preset_rand be=%b got=%h exp=%h", be, r, m_preset);
      end
    end
  endtask

  // Expiry model: COUNT = P at E2, one less per edge, irq at E(max(P,1)+2).
  task automatic test_oneshot(input int unsigned p);
    logic [31:0] r;
    logic [31:0] exp_cnt;
    int unsigned pe;
    pe = (p == 0) ? 1 : p;
    bus_write(A_PRESET, p, 4'hF);
    m_preset = p;
    bus_write(A_CTRL, 32'h9, 4'hF);
    for (int unsigned k = 1; k <= pe + 4; k++) begin
      tick();
      bus_read(A_COUNT, r);
      if (k >= 2) begin
        exp_cnt = (p >= k - 2) ? (p - (k - 2)) : 32'h0;
        n_checks++;
        if (r !== exp_cnt) begin
          n_fail++;
          $display("FAIL oneshot_count P=%0d k=%0d got=%0d exp=%0d", p, k, r, exp_cnt);
        end
      end
      n_checks++;
      if (irq !== (k >= pe + 2)) begin
        n_fail++;
        $display("FAIL oneshot_irq P=%0d k=%0d got=%b exp=%b", p, k, irq, (k >= pe + 2));
      end
    end
    bus_read(A_CTRL, r);
    n_checks++;
    if (r !== 32'h8) begin
      n_fail++;
      $display("FAIL oneshot_ctrl_en P=%0d got=%h exp=00000008", p, r);
    end
    bus_write(A_CTRL, 32'h8, 4'b0001);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_clear P=%0d got=%b exp=0", p, irq);
    end
  endtask

  // Pulses expected at k = Pe+2 + n*(Pe+3).
  task automatic test_reload(input int unsigned p);
    int unsigned pe;
    int unsigned last;
    int pulses;
    logic exp_irq;
    pe = (p == 0) ? 1 : p;
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_write(A_PRESET, p, 4'hF);
    m_preset = p;
    bus_write(A_CTRL, 32'hB, 4'hF);
    last = pe + 2 + 4 * (pe + 3);
    pulses = 0;
    for (int unsigned k = 1; k <= last; k++) begin
      tick();
      exp_irq = (k >= pe + 2) && (((k - pe - 2) % (pe + 3)) == 0);
      n_checks++;
      if (irq !== exp_irq) begin
        n_fail++;
        $display("FAIL reload_irq P=%0d k=%0d got=%b exp=%b", p, k, irq, exp_irq);
      end
      if (irq === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 5) begin
      n_fail++;
      $display("FAIL reload_pulses P=%0d got=%0d exp=5", p, pulses);
    end
    bus_write(A_CTRL, 32'h0, 4'hF);
    pulses = 0;
    for (int unsigned k = 0; k < 3 * (pe + 3); k++) begin
      tick();
      if (irq === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reload_stop P=%0d got=%0d pulses exp=0", p, pulses);
    end
  endtask

  task automatic test_mask();
    logic [31:0] r;
    int seen;
    bus_write(A_PRESET, 32'd2, 4'hF);
    m_preset = 32'd2;
    bus_write(A_CTRL, 32'h1, 4'hF);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (irq !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mask_hidden got=%0d high cycles exp=0", seen);
    end
    bus_read(A_CTRL, r);
    n_checks++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL mask_ctrl got=%h exp=00000000", r);
    end
    bus_write(A_CTRL, 32'h8, 4'b0001);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (irq !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mask_unmask got=%0d high cycles exp=0", seen);
    end
    bus_read(A_CTRL, r);
    n_checks++;
    if (r !== 32'h8) begin
      n_fail++;
      $display("FAIL mask_ctrl_im got=%h exp=00000008", r);
    end
  endtask

  task automatic test_disturb();
    logic [31:0] r;
    int seen;
    bus_write(A_PRESET, 32'd10, 4'hF);
    m_preset = 32'd10;
    bus_write(A_CTRL, 32'h9, 4'hF);
    for (int k = 1; k <= 7; k++) tick();
    bus_read(A_COUNT, r);
    n_checks++;
    if (r !== 32'd5) begin
      n_fail++;
      $display("FAIL disturb_count5 got=%0d exp=5", r);
    end
    bus_write(A_CTRL, 32'h8, 4'b0001);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus_read(A_COUNT, r);
      if (r !== 32'd5 || irq !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL disturb_hold got=%0d bad cycles exp=0 (count=%0d)", seen, r);
    end
    bus_write(A_CTRL, 32'h9, 4'hF);
    tick();
    bus_read(A_COUNT, r);
    n_checks++;
    if (r !== 32'd5) begin
      n_fail++;
      $display("FAIL reenable_load got=%0d exp=5", r);
    end
    tick();
    bus_read(A_COUNT, r);
    n_checks++;
    if (r !== 32'd10) begin
      n_fail++;
      $display("FAIL reenable_reload got=%0d exp=10", r);
    end
    for (int k = 0; k < 3; k++) tick();
    bus_write(A_PRESET, 32'd20, 4'hF);
    m_preset = 32'd20;
    bus_read(A_COUNT, r);
    n_checks++;
    if (r !== 32'd7) begin
      n_fail++;
      $display("FAIL preset_write_hold got=%0d exp=7", r);
    end
    tick();
    tick();
    bus_read(A_COUNT, r);
    n_checks++;
    if (r !== 32'd20) begin
      n_fail++;
      $display("FAIL preset_write_restart got=%0d exp=20", r);
    end
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_preset = 32'h0;
    seen = 0;
    bus_read(A_CTRL, r);
    if (r !== 32'h0) seen++;
    bus_read(A_PRESET, r);
    if (r !== 32'h0) seen++;
    tick();
    bus_read(A_COUNT, r);
    if (r !== 32'h0) seen++;
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midreset_regs got=%0d nonzero regs exp=0", seen);
    end
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (irq !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midreset_irq got=%0d high cycles exp=0", seen);
    end
  endtask

  task automatic test_decode();
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] exp_cnt;
    bus_write(A_PRESET, 32'd8, 4'hF);
    m_preset = 32'd8;
    bus_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_PRESET, r);
    n_checks++;
    if (r !== m_preset) begin
      n_fail++;
      $display("FAIL decode_outside_preset got=%h exp=%h", r, m_preset);
    end
    bus_read(A_CTRL, r);
    n_checks++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL decode_outside_ctrl got=%h exp=00000000", r);
    end
    bus_write(A_CTRL, 32'h9, 4'hF);
    for (int unsigned k = 1; k <= 12; k++) begin
      if (k == 4) bus_write(A_COUNT, 32'h55, 4'hF);
      else if (k == 6) bus_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
      else tick();
      bus_read(A_COUNT, r);
      if (k >= 2) begin
        exp_cnt = (8 >= k - 2) ? (8 - (k - 2)) : 32'h0;
        n_checks++;
        if (r !== exp_cnt) begin
          n_fail++;
          $display("FAIL decode_count_write k=%0d got=%0d exp=%0d", k, r, exp_cnt);
        end
      end
      n_checks++;
      if (irq !== (k >= 10)) begin
        n_fail++;
        $display("FAIL decode_irq k=%0d got=%b exp=%b", k, irq, (k >= 10));
      end
    end
    bus_read(A_RSVD, r);
    n_checks++;
    if (r !== 32'h0) begin
      n_fail++;
      $display("FAIL decode_reserved got=%h exp=00000000", r);
    end
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      if (a[31:4] == BASE[31:4]) a = a ^ 32'h1000_0000;
      bus_read(a, r);
      n_checks++;
      if (r !== 32'h0) begin
        n_fail++;
        $display("FAIL decode_unselected addr=%h got=%h exp=00000000", a, r);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_preset = 32'h0;
    reset    = 1'b0;
    addr     = 32'h0;
    we       = 1'b0;
    byteen   = 4'b0000;
    wdata    = 32'h0;

    test_reset();
    test_oneshot(3);
    for (int i = 0; i < 3; i++) test_oneshot($urandom_range(1, 12));
    test_reload(2);
    test_reload($urandom_range(1, 6));
    test_mask();
    test_disturb();
    test_decode();
    test_oneshot(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Memory-mapped, 32-bit down-counting timer attached to the CPU data bus behind the bridge. It drives one bit of the datapath's HWInt interrupt input. The datapath writes CTRL and PRESET through m_data_addr/m_data_wdata/m_data_byteen and reads COUNT back. On expiry the block raises an interrupt, either one-shot or periodic with auto-reload.

Parameters:
BASE_ADDR, 32'h0000_7F00, word-aligned base address; block decodes a 16-byte window.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
addr  in  32  byte address from bus (m_data_addr)
we  in  1  write strobe; write takes effect only when address is selected
byteen  in  4  byte-lane enables for the write
wdata  in  32  write data
rdata  out  32  read data, combinational on addr
irq  out  1  interrupt request, to one HWInt bit

Behaviour:
- Select: sel = (addr[31:4] == BASE_ADDR[31:4]). Offset addr[3:2] chooses the register: 0 = CTRL, 1 = PRESET, 2 = COUNT (read-only), 3 = reserved.
- CTRL bits:
  - [0] EN: enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload; 10/11 behave as 00.
  - [3] IM: interrupt mask, 1 = allow.
  - [31:4] read as 0 and ignore writes.
- Writes: per-lane, so lane i is written only when byteen[i] is set. Writes to COUNT or reserved are ignored. Writes with sel = 0 are ignored.
- Read: rdata = selected register, zero-extended. Reserved or unselected returns 32'h0. No read latency.
- Reset (reset == 0 at a clk edge): CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, irq_flag = 0, irq = 0. Reset mid-count aborts immediately, with no interrupt.
- irq = irq_flag & CTRL.IM. Masking hides irq_flag but does not clear it.
- FSM, one transition per edge:
  - IDLE: if EN, go to LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - if !EN, go to IDLE with COUNT held;
    - else if COUNT > 1, COUNT <= COUNT - 1;
    - else (COUNT is 0 or 1), COUNT <= 0, irq_flag <= 1, go to INT.
  - INT:
    - MODE 00: CTRL.EN <= 0; go to IDLE. irq_flag stays set until CPU clears it.
    - MODE 01: irq_flag <= 0, giving a one-cycle pulse; go to IDLE. EN stays 1, so the timer reloads.
- Latency: EN written at edge E0 gives LOAD at E1, COUNT = P at E2, and irq_flag at E(P+2) for P ≥ 1. P = 0 fires at E3, the same as P = 1.
- Auto-reload period: P+3 cycles between irq rising edges.
- Any bus write to CTRL or PRESET (sel, we, any byteen set):
  - clears irq_flag;
  - forces state <= IDLE;
  - leaves COUNT unchanged.
  - The CPU write has priority over the FSM's same-edge update of CTRL.EN or irq_flag.
- Disabling EN while in INT in MODE 01: next state is IDLE and no reload occurs.
- COUNT never underflows; 0 is the terminal value. PRESET = 32'hFFFF_FFFF counts normally, with no overflow path.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, LOAD, CNT, INT, 2 bits);
  - register offsets (CTRL = 2'd0, PRESET = 2'd1, COUNT = 2'd2);
  - CTRL bit positions (EN = 0, MODE = 2:1, IM = 3);
  - mode codes (ONESHOT = 2'b00, RELOAD = 2'b01).
- Single module; no sub-module is warranted. The bridge instantiates it and routes irq to HWInt[0].

Test Plan:
- Reset and readback:
  - Hold reset = 0 for 2 cycles, then release. Reads of 0x7F00/04/08/0C all return 0 and irq = 0.
  - Write PRESET = 32'h1234_5678 with byteen = 4'b0011, then read PRESET: returns 32'h0000_5678.
- One-shot:
  - PRESET = 3, then CTRL = 4'b1001 at E0.
  - COUNT reads 3/2/1/0 at E2..E5; irq rises after E5 and stays high; CTRL.EN reads 0.
  - Writing CTRL = 4'b1000 drops irq on the next edge.
- Auto-reload:
  - PRESET = 2, CTRL = 4'b1011.
  - irq is a 1-cycle pulse every 5 cycles, for at least 4 pulses.
  - Writing CTRL = 0 stops the pulses.
- Mask:
  - One-shot expiry with IM = 0: irq stays 0.
  - Then set IM = 1 by a byteen = 4'b0001 write of 4'b1000: irq stays 0, because the CTRL write cleared irq_flag.
- Mid-count disturbances:
  - Disable EN at COUNT = 5: COUNT holds 5 and state goes to IDLE.
  - Re-enable: reloads from PRESET.
  - Write PRESET during CNT: restarts via IDLE/LOAD.
  - Pulse reset = 0 mid-count: all registers return to 0 and no irq occurs.
- Decode:
  - Writes to BASE_ADDR + 0x10 and to COUNT have no effect.
  - Reads with addr outside the window return 0.
  - PRESET = 0 with EN set: irq after E3.
